// File: rtl/tinymind_pkg.sv
// Shared types and widths for the layer sequencer and its watchdog.
package tinymind_pkg;
    localparam int LAYER_W  = 4;
    localparam int NEURON_W = 8;
    localparam int WDOG_W   = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        NEXT
    } seq_state_t;
endpackage

// File: rtl/layer_sequencer_if.sv
// Handshake bundle between the layer sequencer, its requester and the compute unit.
interface layer_sequencer_if;
    import tinymind_pkg::*;

    logic                start;
    logic [NEURON_W-1:0] cfg_neurons;
    logic                unit_done;
    logic                unit_start;
    logic [LAYER_W-1:0]  unit_layer;
    logic [NEURON_W-1:0] unit_neuron;
    logic                busy;
    logic                done_r;
    logic                timeout_err;

    modport master (
        output start, cfg_neurons, unit_done,
        input  unit_start, unit_layer, unit_neuron, busy, done_r, timeout_err
    );

    modport slave (
        input  start, cfg_neurons, unit_done,
        output unit_start, unit_layer, unit_neuron, busy, done_r, timeout_err
    );
endinterface

// File: rtl/tinymind_watchdog.sv
// Per-neuron wait counter; expired flags the limit-th consecutive enabled cycle.
module tinymind_watchdog
    import tinymind_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              enable,
    input  logic [WDOG_W-1:0] limit,
    output logic              expired
);
    logic [WDOG_W-1:0] count_reg;

    // A zero limit never expires; the counter stops once it has expired.
    assign expired = enable && (limit != '0) && (count_reg == limit - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && !expired) begin
            count_reg <= count_reg + 1'b1;
        end
    end
endmodule

// File: rtl/layer_sequencer.sv
// Walks every (layer, neuron) pair, handing each to the compute unit and
// waiting for its completion under a watchdog.
module layer_sequencer
    import tinymind_pkg::*;
#(
    parameter int NUM_LAYERS = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    layer_sequencer_if.slave bus
);
    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
    localparam logic [WDOG_W-1:0]  WD_LIMIT   = WDOG_W'(TIMEOUT);

    seq_state_t          state_reg;
    logic [NEURON_W-1:0] count_reg;
    logic [NEURON_W-1:0] neuron_reg;
    logic [LAYER_W-1:0]  layer_reg;
    logic                unit_start_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                err_reg;
    logic                wd_clear;
    logic                wd_enable;
    logic                wd_expired;

    // Gating enable with unit_done gives completion priority over expiry.
    assign wd_clear  = (state_reg == ISSUE);
    assign wd_enable = (state_reg == WAIT) && !bus.unit_done;

    tinymind_watchdog u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .limit   (WD_LIMIT),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            neuron_reg     <= '0;
            layer_reg      <= '0;
            unit_start_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            unit_start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.cfg_neurons != '0) begin
                            count_reg      <= bus.cfg_neurons;
                            neuron_reg     <= '0;
                            layer_reg      <= '0;
                            done_reg       <= 1'b0;
                            err_reg        <= 1'b0;
                            busy_reg       <= 1'b1;
                            unit_start_reg <= 1'b1;
                            state_reg      <= ISSUE;
                        end else begin
                            done_reg <= 1'b1;
                        end
                    end
                end
                ISSUE: state_reg <= WAIT;
                WAIT: begin
                    if (bus.unit_done) begin
                        state_reg <= NEXT;
                    end else if (wd_expired) begin
                        err_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                NEXT: begin
                    // Limits are compared before incrementing, so indices never wrap.
                    if (neuron_reg != count_reg - 1'b1) begin
                        neuron_reg     <= neuron_reg + 1'b1;
                        unit_start_reg <= 1'b1;
                        state_reg      <= ISSUE;
                    end else if (layer_reg != LAST_LAYER) begin
                        neuron_reg     <= '0;
                        layer_reg      <= layer_reg + 1'b1;
                        unit_start_reg <= 1'b1;
                        state_reg      <= ISSUE;
                    end else begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.unit_start  = unit_start_reg;
    assign bus.unit_layer  = layer_reg;
    assign bus.unit_neuron = neuron_reg;
    assign bus.busy        = busy_reg;
    assign bus.done_r      = done_reg;
    assign bus.timeout_err = err_reg;
endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench: table of directed runs, reset abort, then random runs
// against an issue-order / cycle-budget model of the sequencer.
module tb_layer_sequencer;
    localparam int NUM_L = 2;
    localparam int TO    = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    layer_sequencer_if bus ();

    layer_sequencer #(.NUM_LAYERS(NUM_L), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cfg;
        int d;
        bit noise;
        int starts;
        int cycles;
        int lat;
        bit done;
        bit err;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_unit_start"}, int'(bus.unit_start), 0);
        check({tag, "_unit_layer"}, int'(bus.unit_layer), 0);
        check({tag, "_unit_neuron"}, int'(bus.unit_neuron), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done_r"}, int'(bus.done_r), 0);
        check({tag, "_timeout_err"}, int'(bus.timeout_err), 0);
    endtask

    // Idle cycles with stray unit_done: flags must hold, nothing may issue.
    task automatic idle_check(input bit exp_done, input bit exp_err);
        for (int i = 0; i < 2; i++) begin
            bus.start     = 1'b0;
            bus.unit_done = 1'($urandom_range(0, 1));
            tick();
            check("idle_unit_start", int'(bus.unit_start), 0);
            check("idle_busy", int'(bus.busy), 0);
            check("idle_done_hold", int'(bus.done_r), int'(exp_done));
            check("idle_err_hold", int'(bus.timeout_err), int'(exp_err));
        end
        bus.unit_done = 1'b0;
    endtask

    // Drives one run acting as requester and compute unit. fixed_d < 0 picks
    // random per-neuron response delays (delay = WAIT cycles before unit_done).
    task automatic do_run(input int cfg, input int fixed_d, input bit noise, input int abort_k,
                          output int n_starts, output int busy_cyc, output int lat,
                          output int exp_starts, output int exp_cyc, output bit exp_done,
                          output bit exp_err);
        int dl[$];
        int exp_l[$];
        int exp_n[$];
        int cd;
        int k;
        bit real_done;
        bit nxt_cycle;
        bit finished;

        for (int l = 0; l < NUM_L; l++) begin
            for (int n = 0; n < cfg; n++) begin
                exp_l.push_back(l);
                exp_n.push_back(n);
                if (fixed_d >= 0) dl.push_back(fixed_d);
                else if ($urandom_range(0, 9) == 0) dl.push_back(int'($urandom_range(TO, TO + 2)));
                else dl.push_back(int'($urandom_range(0, TO - 1)));
            end
        end

        exp_starts = 0;
        exp_cyc    = 0;
        exp_err    = 1'b0;
        foreach (dl[i]) begin
            exp_starts++;
            if (dl[i] >= TO) begin
                exp_cyc += 1 + TO;
                exp_err = 1'b1;
                break;
            end
            exp_cyc += dl[i] + 3;
        end
        exp_done = !exp_err;

        bus.cfg_neurons = 8'(cfg);
        bus.start       = 1'b1;
        bus.unit_done   = 1'b0;
        cd = 0; k = 0; busy_cyc = 0; lat = 0; nxt_cycle = 1'b0; finished = 1'b0;
        n_starts = 0;

        for (int guard = 0; guard < 400; guard++) begin
            tick();
            real_done = 1'b0;
            if (cd > 0) begin
                cd--;
                real_done = (cd == 0);
            end
            if (bus.unit_start) begin
                if (k < exp_l.size()) begin
                    check("issue_layer", int'(bus.unit_layer), exp_l[k]);
                    check("issue_neuron", int'(bus.unit_neuron), exp_n[k]);
                    cd = dl[k] + 1;
                end else begin
                    check("issue_count_overflow", k + 1, exp_l.size());
                end
                k++;
                if (k - 1 == abort_k) begin
                    n_starts      = k;
                    bus.start     = 1'b0;
                    bus.unit_done = 1'b0;
                    return;
                end
            end else if (bus.busy && k > 0 && k <= exp_l.size()) begin
                check("hold_layer", int'(bus.unit_layer), exp_l[k-1]);
                check("hold_neuron", int'(bus.unit_neuron), exp_n[k-1]);
            end
            if (!bus.busy) begin
                lat      = guard + 1;
                finished = 1'b1;
                break;
            end
            busy_cyc++;
            check("busy_flags_clear", int'(bus.done_r) + int'(bus.timeout_err), 0);
            bus.unit_done = real_done;
            if (!real_done && noise && (bus.unit_start || nxt_cycle))
                bus.unit_done = 1'($urandom_range(0, 1));
            nxt_cycle = real_done;
            bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) bus.cfg_neurons = 8'($urandom);
        end
        bus.start     = 1'b0;
        bus.unit_done = 1'b0;
        n_starts      = k;
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL run_guard actual=still_busy required=idle");
        end
    endtask

    vec_t vecs[6];

    initial begin
        int ns, bc, lt, es, ec;
        bit ed, ee;

        vecs[0] = '{3, 0, 1'b0, 6, 18, 19, 1'b1, 1'b0};
        vecs[1] = '{0, 0, 1'b0, 0, 0, 1, 1'b1, 1'b0};
        vecs[2] = '{1, 5, 1'b0, 1, 6, 7, 1'b0, 1'b1};
        vecs[3] = '{2, 4, 1'b0, 4, 28, 29, 1'b1, 1'b0};
        vecs[4] = '{3, 1, 1'b1, 6, 24, 25, 1'b1, 1'b0};
        vecs[5] = '{1, 0, 1'b0, 2, 6, 7, 1'b1, 1'b0};

        bus.start       = 1'b0;
        bus.cfg_neurons = '0;
        bus.unit_done   = 1'b0;
        repeat (2) tick();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            do_run(vecs[i].cfg, vecs[i].d, vecs[i].noise, -1, ns, bc, lt, es, ec, ed, ee);
            $display("vec %0d cfg=%0d delay=%0d noise=%0d starts=%0d cycles=%0d lat=%0d done=%0d err=%0d",
                     i, vecs[i].cfg, vecs[i].d, vecs[i].noise, ns, bc, lt, bus.done_r, bus.timeout_err);
            check("vec_starts", ns, vecs[i].starts);
            check("vec_cycles", bc, vecs[i].cycles);
            check("vec_latency", lt, vecs[i].lat);
            check("vec_done_r", int'(bus.done_r), int'(vecs[i].done));
            check("vec_timeout_err", int'(bus.timeout_err), int'(vecs[i].err));
            idle_check(vecs[i].done, vecs[i].err);
        end

        // Reset while the (1,1) neuron is being issued.
        do_run(3, 0, 1'b0, 4, ns, bc, lt, es, ec, ed, ee);
        check("abort_reached", ns, 5);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrun_reset");
        tick();
        #2 rst_n = 1'b1;
        repeat (3) begin
            tick();
            check_outputs_zero("post_reset");
        end
        $display("reset abort at start %0d, outputs cleared", ns);
        do_run(3, 0, 1'b0, -1, ns, bc, lt, es, ec, ed, ee);
        $display("rerun cfg=3 starts=%0d cycles=%0d done=%0d", ns, bc, bus.done_r);
        check("rerun_starts", ns, 6);
        check("rerun_cycles", bc, 18);
        check("rerun_done_r", int'(bus.done_r), 1);
        idle_check(1'b1, 1'b0);

        for (int r = 0; r < 12; r++) begin
            int cfg;
            bit nz;
            cfg = int'($urandom_range(1, 4));
            nz  = 1'($urandom_range(0, 1));
            do_run(cfg, -1, nz, -1, ns, bc, lt, es, ec, ed, ee);
            $display("rand %0d cfg=%0d noise=%0d starts=%0d/%0d cycles=%0d/%0d done=%0d err=%0d",
                     r, cfg, nz, ns, es, bc, ec, bus.done_r, bus.timeout_err);
            check("rand_starts", ns, es);
            check("rand_cycles", bc, ec);
            check("rand_latency", lt, ec + 1);
            check("rand_done_r", int'(bus.done_r), int'(ed));
            check("rand_timeout_err", int'(bus.timeout_err), int'(ee));
            idle_check(ed, ee);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 2, meaning layers per run (1..15).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning maximum WAIT cycles per neuron; 0 disables the watchdog.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, run request; sampled only in IDLE.
REQ-006 SHALL have port cfg_neurons, input, 8, neurons per layer; captured when start is accepted.
REQ-007 SHALL have port unit_done, input, 1, completion from the compute unit; honoured only in WAIT.
REQ-008 SHALL have port unit_start, output, 1, one-cycle request to the compute unit.
REQ-009 SHALL have port unit_layer, output, 4, index of the current layer.
REQ-010 SHALL have port unit_neuron, output, 8, index of the current neuron.
REQ-011 SHALL have port busy, output, 1, high while a run is in progress.
REQ-012 SHALL have port done_r, output, 1, sticky run-complete flag.
REQ-013 SHALL have port timeout_err, output, 1, sticky watchdog-expiry flag.

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT, NEXT.
REQ-015 IDLE with start=1 and cfg_neurons!=0 SHALL capture cfg_neurons, clear layer, neuron, done_r and timeout_err, set busy, and go to ISSUE.
REQ-016 IDLE with start=1 and cfg_neurons=0 SHALL set done_r=1 on the next cycle, stay in IDLE, and issue no unit_start.
REQ-017 ISSUE SHALL drive unit_start=1 for exactly one cycle, clear the watchdog, and go to WAIT.
REQ-018 WAIT with unit_done=1 SHALL go to NEXT.
REQ-019 WAIT with unit_done=0 SHALL increment the watchdog.
REQ-020 When the watchdog reaches TIMEOUT (TIMEOUT!=0), the block SHALL set timeout_err=1, clear busy, leave done_r=0, and go to IDLE.
REQ-021 unit_done=1 in the cycle the watchdog expires SHALL take priority: the block goes to NEXT with no error.
REQ-022 NEXT, not at the last neuron, SHALL increment the neuron index and go to ISSUE.
REQ-023 NEXT, at the last neuron (captured count minus 1) of a non-final layer, SHALL clear the neuron index, increment the layer index, and go to ISSUE.
REQ-024 NEXT, at the last neuron of layer NUM_LAYERS-1, SHALL go to IDLE, set done_r=1, and clear busy on the same edge.
REQ-025 Per-neuron latency SHALL be 3 cycles when unit_done returns in the first WAIT cycle.
REQ-026 done_r SHALL be visible 1 cycle after the final NEXT.
REQ-027 unit_layer and unit_neuron SHALL be stable from ISSUE through NEXT for each neuron.
REQ-028 start while busy=1 SHALL be ignored.
REQ-029 unit_done outside WAIT SHALL be ignored.
REQ-030 Changes on cfg_neurons during a run SHALL be ignored.
REQ-031 done_r and timeout_err SHALL hold until the next accepted start or reset.
REQ-032 Index arithmetic SHALL be unsigned.
REQ-033 The index counters SHALL never wrap: the final comparison occurs before any increment past the limit.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE and set all outputs to 0: unit_start, unit_layer, unit_neuron, busy, done_r, timeout_err.
REQ-035 rst_n=0 SHALL clear the watchdog and the captured cfg_neurons.
REQ-036 Reset asserted mid-run SHALL abandon the run with no done_r and no timeout_err after release.
REQ-037 After reset release, the block SHALL wait for a new start.

Structure
REQ-038 tinymind_pkg SHALL hold the state enumeration, the index widths (4 and 8), and the watchdog width (16).
REQ-039 The watchdog SHALL be the sub-module tinymind_watchdog, with inputs clear, enable, and limit, and output expired.
REQ-040 The FSM and the index counters SHALL reside in layer_sequencer.

Verification
REQ-041 The bench SHALL cover: NUM_LAYERS=2, cfg_neurons=3, unit_done one cycle after each unit_start -> 6 unit_start pulses with (layer,neuron) (0,0)..(1,2), and done_r=1 19 cycles after the start edge.
REQ-042 The bench SHALL cover: cfg_neurons=0 with start -> done_r=1 next cycle, no unit_start, and busy stays 0.
REQ-043 The bench SHALL cover: TIMEOUT=5 with unit_done never asserted -> timeout_err=1 after 5 WAIT cycles, busy=0, done_r=0.
REQ-044 The bench SHALL cover: unit_done coinciding with watchdog expiry -> no timeout_err and the run completes.
REQ-045 The bench SHALL cover: rst_n pulsed low at neuron (1,1) -> all outputs 0 at once; a new start then runs from (0,0).
REQ-046 The bench SHALL cover: start and unit_done toggled while busy and in ISSUE/NEXT -> no extra unit_start and unchanged index sequence.
